// File: rtl/mips_pkg.sv
// Shared MIPS definitions: the funct codes of the HI/LO-class instructions and
// the state encoding of the multiply/divide sequencer.
package mips_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/mult_div_iter.sv
// One combinational step of the iterative datapath: shift-add multiply or
// restoring divide, operating on a {hi, lo} double-width accumulator.
module mult_div_iter #(
    parameter int NBITS = 32
) (
    input  logic             mode_div_i,
    input  logic [NBITS-1:0] hi_i,
    input  logic [NBITS-1:0] lo_i,
    input  logic [NBITS-1:0] opnd_i,
    output logic [NBITS-1:0] hi_o,
    output logic [NBITS-1:0] lo_o
);

    logic [NBITS:0]   sum;
    logic [NBITS:0]   top;
    logic [NBITS-1:0] rem_sub;
    logic             fits;

    always_comb begin
        sum     = {1'b0, hi_i} + {1'b0, opnd_i};
        // Divide: remainder shifted left needs one extra bit before the trial subtract.
        top     = {hi_i, lo_i[NBITS-1]};
        fits    = (top >= {1'b0, opnd_i});
        rem_sub = top[NBITS-1:0] - opnd_i;

        if (mode_div_i) begin
            hi_o = fits ? rem_sub : top[NBITS-1:0];
            lo_o = {lo_i[NBITS-2:0], fits};
        end else begin
            // lo holds the remaining multiplier bits; product bits shift in from the top.
            hi_o = lo_i[0] ? sum[NBITS:1] : {1'b0, hi_i[NBITS-1:1]};
            lo_o = {(lo_i[0] ? sum[0] : hi_i[0]), lo_i[NBITS-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// HI/LO unit for the EX stage: sequences MULT/MULTU/DIV/DIVU one bit per
// cycle, owns HI/LO, serves MTHI/MTLO/MFHI/MFLO and stalls the pipeline.
module mult_div_sequencer
    import mips_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int NBITSFUNCT = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_Start,
    input  logic [NBITSFUNCT-1:0] i_Funct,
    input  logic [NBITS-1:0]      i_RS,
    input  logic [NBITS-1:0]      i_RT,
    output logic                  o_Stall,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_DivByZero,
    output logic [NBITS-1:0]      o_Result,
    output logic [NBITS-1:0]      o_HI,
    output logic [NBITS-1:0]      o_LO
);

    localparam int CW = $clog2(NBITS);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] opnd_q, opnd_d;
    logic [NBITS-1:0] acc_hi_q, acc_hi_d;
    logic [NBITS-1:0] acc_lo_q, acc_lo_d;
    logic [NBITS-1:0] hi_q, hi_d;
    logic [NBITS-1:0] lo_q, lo_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             is_div_q, is_div_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             dbz_pulse_q, dbz_pulse_d;

    logic [NBITS-1:0]   iter_hi, iter_lo;
    logic [2*NBITS-1:0] prod;
    logic               op_signed;

    function automatic logic [NBITS-1:0] mag(input logic [NBITS-1:0] x, input logic sgn);
        return (sgn && x[NBITS-1]) ? ({NBITS{1'b0}} - x) : x;
    endfunction

    mult_div_iter #(.NBITS(NBITS)) u_iter (
        .mode_div_i (state_q == ST_DIV),
        .hi_i       (acc_hi_q),
        .lo_i       (acc_lo_q),
        .opnd_i     (opnd_q),
        .hi_o       (iter_hi),
        .lo_o       (iter_lo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opnd_d      = opnd_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        is_div_d    = is_div_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        dbz_pulse_d = 1'b0;
        op_signed   = (i_Funct == FUNCT_MULT) || (i_Funct == FUNCT_DIV);
        prod        = {acc_hi_q, acc_lo_q};

        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    case (i_Funct)
                        FUNCT_MTHI: hi_d = i_RS;
                        FUNCT_MTLO: lo_d = i_RS;
                        FUNCT_MULT, FUNCT_MULTU: begin
                            opnd_d   = mag(i_RS, op_signed);
                            acc_hi_d = '0;
                            acc_lo_d = mag(i_RT, op_signed);
                            neg_lo_d = op_signed & (i_RS[NBITS-1] ^ i_RT[NBITS-1]);
                            neg_hi_d = op_signed & (i_RS[NBITS-1] ^ i_RT[NBITS-1]);
                            is_div_d = 1'b0;
                            dbz_d    = 1'b0;
                            cnt_d    = CW'(NBITS - 1);
                            state_d  = ST_MUL;
                        end
                        FUNCT_DIV, FUNCT_DIVU: begin
                            is_div_d = 1'b1;
                            if (i_RT == '0) begin
                                dbz_d   = 1'b1;
                                state_d = ST_FIX;
                            end else begin
                                opnd_d   = mag(i_RT, op_signed);
                                acc_hi_d = '0;
                                acc_lo_d = mag(i_RS, op_signed);
                                neg_lo_d = op_signed & (i_RS[NBITS-1] ^ i_RT[NBITS-1]);
                                neg_hi_d = op_signed & i_RS[NBITS-1];
                                dbz_d    = 1'b0;
                                cnt_d    = CW'(NBITS - 1);
                                state_d  = ST_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                acc_hi_d = iter_hi;
                acc_lo_d = iter_lo;
                if (cnt_q == '0) state_d = ST_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_FIX: begin
                done_d = 1'b1;
                if (dbz_q) begin
                    dbz_pulse_d = 1'b1;
                end else if (is_div_q) begin
                    lo_d = neg_lo_q ? ({NBITS{1'b0}} - acc_lo_q) : acc_lo_q;
                    hi_d = neg_hi_q ? ({NBITS{1'b0}} - acc_hi_q) : acc_hi_q;
                end else begin
                    // Product sign applies to the full double-width value.
                    if (neg_lo_q) prod = {(2*NBITS){1'b0}} - {acc_hi_q, acc_lo_q};
                    hi_d = prod[2*NBITS-1:NBITS];
                    lo_d = prod[NBITS-1:0];
                end
                dbz_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            opnd_q      <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            is_div_q    <= 1'b0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
            dbz_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opnd_q      <= opnd_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            is_div_q    <= is_div_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
            dbz_pulse_q <= dbz_pulse_d;
        end
    end

    always_comb begin
        o_Result = '0;
        if (i_Start && i_Funct == FUNCT_MFHI)      o_Result = hi_q;
        else if (i_Start && i_Funct == FUNCT_MFLO) o_Result = lo_q;
    end

    assign o_Busy      = (state_q != ST_IDLE);
    assign o_Stall     = o_Busy & i_Start;
    assign o_Done      = done_q;
    assign o_DivByZero = dbz_pulse_q;
    assign o_HI        = hi_q;
    assign o_LO        = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: hand-computed MULT/DIV results,
// latency, divide-by-zero, stall/back-to-back MFLO and asynchronous reset.
module tb_mult_div_sequencer;

    logic        i_clk;
    logic        i_reset;
    logic        i_Start;
    logic [5:0]  i_Funct;
    logic [31:0] i_RS;
    logic [31:0] i_RT;
    logic        o_Stall;
    logic        o_Busy;
    logic        o_Done;
    logic        o_DivByZero;
    logic [31:0] o_Result;
    logic [31:0] o_HI;
    logic [31:0] o_LO;

    int passed = 0;
    int total  = 0;
    int n;

    mult_div_sequencer #(.NBITS(32), .NBITSFUNCT(6)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_Start     (i_Start),
        .i_Funct     (i_Funct),
        .i_RS        (i_RS),
        .i_RT        (i_RT),
        .o_Stall     (o_Stall),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_DivByZero (o_DivByZero),
        .o_Result    (o_Result),
        .o_HI        (o_HI),
        .o_LO        (o_LO)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drive a start on the next edge (edge k), then drop i_Start.
    task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        i_Start = 1'b1; i_Funct = f; i_RS = rs; i_RT = rt;
        step();
        i_Start = 1'b0; i_Funct = 6'h00;
    endtask

    // Count edges after edge k until o_Done, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (o_Done) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        i_reset = 1'b1; i_Start = 1'b0; i_Funct = 6'h00; i_RS = '0; i_RT = '0;
        step();
        check("rst_hi", o_HI, 32'h0);
        check("rst_lo", o_LO, 32'h0);
        check("rst_busy", {31'b0, o_Busy}, 32'h0);
        check("rst_stall", {31'b0, o_Stall}, 32'h0);
        check("rst_done", {31'b0, o_Done}, 32'h0);
        check("rst_result", o_Result, 32'h0);
        i_reset = 1'b0;
        step();

        // MULTU 0xFFFFFFFF * 0xFFFFFFFF
        issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy", {31'b0, o_Busy}, 32'h1);
        wait_done(n);
        check("multu_latency", n, 33);
        check("multu_hi", o_HI, 32'hFFFF_FFFE);
        check("multu_lo", o_LO, 32'h0000_0001);
        check("multu_busy_after", {31'b0, o_Busy}, 32'h0);
        step();
        check("multu_done_pulse", {31'b0, o_Done}, 32'h0);

        // MULT -3 * 7 = -21
        issue(6'h18, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_done(n);
        check("mult_latency", n, 33);
        check("mult_hi", o_HI, 32'hFFFF_FFFF);
        check("mult_lo", o_LO, 32'hFFFF_FFEB);

        // DIV -7 / 2 = -3 rem -1
        issue(6'h1A, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(n);
        check("div_latency", n, 33);
        check("div_lo", o_LO, 32'hFFFF_FFFD);
        check("div_hi", o_HI, 32'hFFFF_FFFF);
        check("div_nodbz", {31'b0, o_DivByZero}, 32'h0);

        // DIV 0x80000000 / -1 wraps
        issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        check("divovf_lo", o_LO, 32'h8000_0000);
        check("divovf_hi", o_HI, 32'h0);

        // DIVU 1000 / 7 = 142 rem 6
        issue(6'h1B, 32'd1000, 32'd7);
        wait_done(n);
        check("divu_lo", o_LO, 32'd142);
        check("divu_hi", o_HI, 32'd6);

        // MTHI/MTLO then DIVU by zero leaves HI/LO alone
        issue(6'h11, 32'h0000_1234, 32'h0);
        issue(6'h13, 32'h0000_1234, 32'h0);
        check("mthi", o_HI, 32'h0000_1234);
        check("mtlo", o_LO, 32'h0000_1234);
        check("mt_nodone", {31'b0, o_Done}, 32'h0);
        issue(6'h1B, 32'd100, 32'd0);
        check("dbz_busy", {31'b0, o_Busy}, 32'h1);
        wait_done(n);
        check("dbz_latency", n, 1);
        check("dbz_flag", {31'b0, o_DivByZero}, 32'h1);
        check("dbz_hi", o_HI, 32'h0000_1234);
        check("dbz_lo", o_LO, 32'h0000_1234);
        step();
        check("dbz_pulse", {31'b0, o_DivByZero}, 32'h0);

        // MULT 6*7 with a stalled MFLO behind it
        issue(6'h18, 32'd6, 32'd7);
        step();
        i_Start = 1'b1; i_Funct = 6'h12;
        #1;
        check("stall_high", {31'b0, o_Stall}, 32'h1);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (!o_Stall) begin
                n = i;
                break;
            end
        end
        check("stall_cycles", n, 32);
        check("mflo_result", o_Result, 32'd42);
        check("mflo_done", {31'b0, o_Done}, 32'h1);
        i_Funct = 6'h10;
        #1;
        check("mfhi_result", o_Result, 32'h0);
        step();
        check("mfhi_idle_nobusy", {31'b0, o_Busy}, 32'h0);
        i_Start = 1'b0;

        // MTHI then asynchronous reset mid-MULT
        issue(6'h11, 32'h0000_CAFE, 32'h0);
        check("mthi_cafe", o_HI, 32'h0000_CAFE);
        issue(6'h18, 32'd123, 32'd456);
        for (int i = 0; i < 10; i++) step();
        i_Start = 1'b1; i_Funct = 6'h10;
        #1;
        check("pre_rst_stall", {31'b0, o_Stall}, 32'h1);
        #1;
        i_reset = 1'b1;
        #1;
        check("arst_hi", o_HI, 32'h0);
        check("arst_lo", o_LO, 32'h0);
        check("arst_busy", {31'b0, o_Busy}, 32'h0);
        check("arst_stall", {31'b0, o_Stall}, 32'h0);
        check("arst_done", {31'b0, o_Done}, 32'h0);
        check("arst_dbz", {31'b0, o_DivByZero}, 32'h0);
        check("arst_result", o_Result, 32'h0);
        i_Start = 1'b0;
        step();
        i_reset = 1'b0;
        step();
        check("post_rst_busy", {31'b0, o_Busy}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
